// File: rtl/axi_up_pkg.sv
// Shared types and constants for the AXI4-Lite to up_* bridge.
// Response codes, per-channel state encoding and the read data returned on timeout.
package axi_up_pkg;

  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR  = 2'b10;
  localparam logic [31:0] UP_TIMEOUT_RDATA = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } chan_state_t;

endpackage

// File: rtl/axi_lite_up_bridge_if.sv
// AXI4-Lite slave channels plus the up_* request/ack bus as seen by the bridge.
// slave = bridge view; master = CPU and peripheral side view.
interface axi_lite_up_bridge_if #(
  parameter int ADDRESS_WIDTH = 14
);

  logic                     s_axi_awvalid;
  logic                     s_axi_awready;
  logic [ADDRESS_WIDTH+1:0] s_axi_awaddr;
  logic                     s_axi_wvalid;
  logic                     s_axi_wready;
  logic [31:0]              s_axi_wdata;
  logic [3:0]               s_axi_wstrb;
  logic                     s_axi_bvalid;
  logic                     s_axi_bready;
  logic [1:0]               s_axi_bresp;
  logic                     s_axi_arvalid;
  logic                     s_axi_arready;
  logic [ADDRESS_WIDTH+1:0] s_axi_araddr;
  logic                     s_axi_rvalid;
  logic                     s_axi_rready;
  logic [31:0]              s_axi_rdata;
  logic [1:0]               s_axi_rresp;

  logic                     up_wreq;
  logic [ADDRESS_WIDTH-1:0] up_waddr;
  logic [31:0]              up_wdata;
  logic                     up_wack;
  logic                     up_rreq;
  logic [ADDRESS_WIDTH-1:0] up_raddr;
  logic [31:0]              up_rdata;
  logic                     up_rack;

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    input  s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
    input  up_wack, up_rdata, up_rack,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp,
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    output s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
    output up_wack, up_rdata, up_rack,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp,
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );

endinterface

// File: rtl/up_req_timer.sv
// One-cycle up_* request pulse, then wait for ack or give up after TIMEOUT_CYCLES; req one cycle after start.
// No backpressure: done pulses for one cycle, the owner must be ready to take it.
module up_req_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic up_clk,
  input  logic up_rst,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic done,
  output logic timed_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic          req_q;
  logic          wait_q;
  logic [CW-1:0] cnt_q;
  logic          at_limit;

  assign at_limit  = (cnt_q == CW'(TIMEOUT_CYCLES));
  assign req       = req_q;
  // An ack in the same cycle as the limit still counts as a successful access.
  assign done      = (req_q && ack) || (wait_q && (ack || at_limit));
  assign timed_out = wait_q && !ack && at_limit;

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      req_q  <= 1'b0;
      wait_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      req_q <= start;
      if (req_q) begin
        wait_q <= !ack;
        cnt_q  <= '0;
      end else if (done) begin
        wait_q <= 1'b0;
      end else if (wait_q && !at_limit) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_up_bridge.sv
// AXI4-Lite slave to up_* bus bridge; one access per channel, response 3 cycles after handshake with a registered ack.
// B/R responses hold until bready/rready; no new address is accepted until the response handshake completes.
module axi_lite_up_bridge
  import axi_up_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 up_clk,
  input  logic                 up_rst,
  axi_lite_up_bridge_if.slave  bus
);

  chan_state_t              w_state, w_state_nxt;
  chan_state_t              r_state, r_state_nxt;
  logic                     w_hs, w_strb_ok, w_start, w_req, w_done, w_timed_out;
  logic                     r_hs, r_start, r_req, r_done, r_timed_out;
  logic [ADDRESS_WIDTH-1:0] waddr_q, raddr_q;
  logic [31:0]              wdata_q, rdata_q;
  logic [1:0]               bresp_q, rresp_q;

  // Write channel: AW and W are taken together so address and data stay paired.
  assign w_hs      = (w_state == IDLE) && bus.s_axi_awvalid && bus.s_axi_wvalid;
  assign w_strb_ok = (bus.s_axi_wstrb == 4'hF);
  assign w_start   = w_hs && w_strb_ok;

  assign bus.s_axi_awready = w_hs;
  assign bus.s_axi_wready  = w_hs;
  assign bus.s_axi_bvalid  = (w_state == RESP);
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.up_wreq       = w_req;
  assign bus.up_waddr      = waddr_q;
  assign bus.up_wdata      = wdata_q;

  up_req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wtimer (
    .up_clk    (up_clk),
    .up_rst    (up_rst),
    .start     (w_start),
    .ack       (bus.up_wack),
    .req       (w_req),
    .done      (w_done),
    .timed_out (w_timed_out)
  );

  always_ff @(posedge up_clk) begin
    if (up_rst) w_state <= IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      IDLE:      if (w_hs) w_state_nxt = w_strb_ok ? REQ : RESP;
      REQ, WAIT: w_state_nxt = w_done ? RESP : WAIT;
      RESP:      if (bus.s_axi_bready) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
      bresp_q <= AXI_RESP_OKAY;
    end else begin
      if (w_hs) begin
        waddr_q <= bus.s_axi_awaddr[ADDRESS_WIDTH+1:2];
        wdata_q <= bus.s_axi_wdata;
      end
      if (w_hs && !w_strb_ok)
        bresp_q <= AXI_RESP_SLVERR;
      else if (w_done)
        bresp_q <= w_timed_out ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end
  end

  // Read channel
  assign r_hs    = (r_state == IDLE) && bus.s_axi_arvalid;
  assign r_start = r_hs;

  assign bus.s_axi_arready = r_hs;
  assign bus.s_axi_rvalid  = (r_state == RESP);
  assign bus.s_axi_rresp   = rresp_q;
  assign bus.s_axi_rdata   = rdata_q;
  assign bus.up_rreq       = r_req;
  assign bus.up_raddr      = raddr_q;

  up_req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rtimer (
    .up_clk    (up_clk),
    .up_rst    (up_rst),
    .start     (r_start),
    .ack       (bus.up_rack),
    .req       (r_req),
    .done      (r_done),
    .timed_out (r_timed_out)
  );

  always_ff @(posedge up_clk) begin
    if (up_rst) r_state <= IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      IDLE:      if (r_hs) r_state_nxt = REQ;
      REQ, WAIT: r_state_nxt = r_done ? RESP : WAIT;
      RESP:      if (bus.s_axi_rready) r_state_nxt = IDLE;
      default:   r_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      raddr_q <= '0;
      rdata_q <= '0;
      rresp_q <= AXI_RESP_OKAY;
    end else begin
      if (r_hs)
        raddr_q <= bus.s_axi_araddr[ADDRESS_WIDTH+1:2];
      if (r_done) begin
        rdata_q <= r_timed_out ? UP_TIMEOUT_RDATA : bus.up_rdata;
        rresp_q <= r_timed_out ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_up_bridge.sv
// Randomized bench for axi_lite_up_bridge against a transaction-level model of latency, response and data.
// A registered-ack peripheral model answers each up_* request after a chosen number of extra cycles (or never).
module tb_axi_lite_up_bridge;
  import axi_up_pkg::*;

  localparam int AW = 14;
  localparam int TO = 8;

  logic up_clk = 1'b0;
  logic up_rst = 1'b1;
  always #5 up_clk = ~up_clk;

  axi_lite_up_bridge_if #(.ADDRESS_WIDTH(AW)) bus ();

  axi_lite_up_bridge #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .up_clk (up_clk),
    .up_rst (up_rst),
    .bus    (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  int w_delay = -1, r_delay = -1;
  int w_cd = 0, r_cd = 0;
  int wreq_cnt = 0, rreq_cnt = 0;
  logic [AW-1:0] cap_waddr, cap_raddr;
  logic [31:0]   cap_wdata;
  logic [31:0]   rd_val = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ack k extra cycles after the registered-ack point, -1 = never.
  function automatic bit acked(input int k);
    return (k >= 0) && (k <= TO);
  endfunction

  function automatic int exp_latency(input int k, input bit bad_strb);
    if (bad_strb)  return 1;
    if (acked(k))  return 3 + k;
    return 3 + TO;
  endfunction

  // Write-side peripheral
  initial begin
    bus.up_wack = 1'b0;
    forever begin
      @(negedge up_clk);
      bus.up_wack = 1'b0;
      if (w_cd > 0) begin
        w_cd--;
        if (w_cd == 0) bus.up_wack = 1'b1;
      end
      if (bus.up_wreq) begin
        wreq_cnt++;
        cap_waddr = bus.up_waddr;
        cap_wdata = bus.up_wdata;
        if (w_delay >= 0) w_cd = w_delay + 1;
      end
    end
  end

  // Read-side peripheral; data is garbage except in the ack cycle
  initial begin
    bus.up_rack  = 1'b0;
    bus.up_rdata = 32'h0;
    forever begin
      @(negedge up_clk);
      bus.up_rack = 1'b0;
      if (r_cd > 0) begin
        r_cd--;
        if (r_cd == 0) bus.up_rack = 1'b1;
      end
      bus.up_rdata = bus.up_rack ? rd_val : $urandom;
      if (bus.up_rreq) begin
        rreq_cnt++;
        cap_raddr = bus.up_raddr;
        if (r_delay >= 0) r_cd = r_delay + 1;
      end
    end
  end

  task automatic do_write(input logic [AW+1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int k, input int hold);
    int lat, w0;
    bit bad;
    logic [1:0] exp_resp;
    bad      = (strb != 4'hF);
    exp_resp = (bad || !acked(k)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    w_delay  = k;
    w0       = wreq_cnt;
    @(negedge up_clk);
    bus.s_axi_awaddr  = addr;
    bus.s_axi_wdata   = data;
    bus.s_axi_wstrb   = strb;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    #1;
    check_eq("awready", 32'(bus.s_axi_awready), 32'd1);
    check_eq("wready", 32'(bus.s_axi_wready), 32'd1);
    lat = 0;
    do begin
      @(negedge up_clk);
      lat++;
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
    end while (!bus.s_axi_bvalid && lat < 60);
    check_eq("b_latency", 32'(lat), 32'(exp_latency(k, bad)));
    check_eq("bresp", 32'(bus.s_axi_bresp), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      bus.s_axi_awvalid = 1'b1;
      bus.s_axi_wvalid  = 1'b1;
      #1;
      check_eq("aw_blocked", 32'(bus.s_axi_awready), 32'd0);
      @(negedge up_clk);
      check_eq("bvalid_hold", 32'(bus.s_axi_bvalid), 32'd1);
      check_eq("bresp_hold", 32'(bus.s_axi_bresp), 32'(exp_resp));
    end
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready  = 1'b1;
    @(negedge up_clk);
    bus.s_axi_bready = 1'b0;
    check_eq("bvalid_clr", 32'(bus.s_axi_bvalid), 32'd0);
    check_eq("wreq_pulses", 32'(wreq_cnt - w0), bad ? 32'd0 : 32'd1);
    if (!bad) begin
      check_eq("up_waddr", 32'(cap_waddr), 32'(addr[AW+1:2]));
      check_eq("up_wdata", cap_wdata, data);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge up_clk);
      check_eq("b_idle", 32'(bus.s_axi_bvalid), 32'd0);
    end
  endtask

  task automatic do_read(input logic [AW+1:0] addr, input logic [31:0] val,
                         input int k, input int hold);
    int lat, r0;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    exp_resp = acked(k) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    exp_data = acked(k) ? val : UP_TIMEOUT_RDATA;
    r_delay  = k;
    rd_val   = val;
    r0       = rreq_cnt;
    @(negedge up_clk);
    bus.s_axi_araddr  = addr;
    bus.s_axi_arvalid = 1'b1;
    #1;
    check_eq("arready", 32'(bus.s_axi_arready), 32'd1);
    lat = 0;
    do begin
      @(negedge up_clk);
      lat++;
      bus.s_axi_arvalid = 1'b0;
    end while (!bus.s_axi_rvalid && lat < 60);
    check_eq("r_latency", 32'(lat), 32'(exp_latency(k, 1'b0)));
    check_eq("rresp", 32'(bus.s_axi_rresp), 32'(exp_resp));
    check_eq("rdata", bus.s_axi_rdata, exp_data);
    for (int i = 0; i < hold; i++) begin
      bus.s_axi_arvalid = 1'b1;
      #1;
      check_eq("ar_blocked", 32'(bus.s_axi_arready), 32'd0);
      @(negedge up_clk);
      check_eq("rvalid_hold", 32'(bus.s_axi_rvalid), 32'd1);
      check_eq("rdata_hold", bus.s_axi_rdata, exp_data);
    end
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b1;
    @(negedge up_clk);
    bus.s_axi_rready = 1'b0;
    check_eq("rvalid_clr", 32'(bus.s_axi_rvalid), 32'd0);
    check_eq("rreq_pulses", 32'(rreq_cnt - r0), 32'd1);
    check_eq("up_raddr", 32'(cap_raddr), 32'(addr[AW+1:2]));
    for (int i = 0; i < 8; i++) begin
      @(negedge up_clk);
      check_eq("r_idle", 32'(bus.s_axi_rvalid), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_awready"}, 32'(bus.s_axi_awready), 32'd0);
    check_eq({tag, "_arready"}, 32'(bus.s_axi_arready), 32'd0);
    check_eq({tag, "_bvalid"}, 32'(bus.s_axi_bvalid), 32'd0);
    check_eq({tag, "_rvalid"}, 32'(bus.s_axi_rvalid), 32'd0);
    check_eq({tag, "_bresp"}, 32'(bus.s_axi_bresp), 32'd0);
    check_eq({tag, "_rresp"}, 32'(bus.s_axi_rresp), 32'd0);
    check_eq({tag, "_rdata"}, bus.s_axi_rdata, 32'd0);
    check_eq({tag, "_wreq"}, 32'(bus.up_wreq), 32'd0);
    check_eq({tag, "_rreq"}, 32'(bus.up_rreq), 32'd0);
    check_eq({tag, "_waddr"}, 32'(bus.up_waddr), 32'd0);
    check_eq({tag, "_wdata"}, bus.up_wdata, 32'd0);
    check_eq({tag, "_raddr"}, 32'(bus.up_raddr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int delays[8] = '{0, 1, 2, 3, 5, 7, 12, -1};
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_awaddr  = '0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_wdata   = '0;
    bus.s_axi_wstrb   = '0;
    bus.s_axi_bready  = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_rready  = 1'b0;

    repeat (3) @(negedge up_clk);
    check_all_zero("reset");
    up_rst = 1'b0;

    do_write(16'h0010, 32'h1234_5678, 4'hF, 0, 0);
    do_read(16'h0008, 32'hCAFE_F00D, 0, 0);
    do_read(16'h0100, 32'h5555_AAAA, 12, 1);
    do_write(16'h0104, 32'h0BAD_0BAD, 4'hF, -1, 0);
    do_write(16'h0020, 32'hFFFF_0000, 4'h3, 0, 0);
    fork
      do_write(16'h0044, 32'hA5A5_5A5A, 4'hF, 1, 5);
      do_read(16'h0048, 32'h0F0F_F0F0, 2, 5);
    join

    // Reset while the write is stuck waiting for an ack that never comes
    w_delay = -1;
    @(negedge up_clk);
    bus.s_axi_awaddr  = 16'h0200;
    bus.s_axi_wdata   = 32'h7777_7777;
    bus.s_axi_wstrb   = 4'hF;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    @(negedge up_clk);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    repeat (3) @(negedge up_clk);
    up_rst = 1'b1;
    @(negedge up_clk);
    check_all_zero("midreset");
    up_rst = 1'b0;
    do_write(16'h0300, 32'h600D_600D, 4'hF, 0, 0);

    for (int it = 0; it < 24; it++) begin
      int op, kw, kr, hw, hr;
      logic [3:0] strb;
      op   = int'($urandom_range(0, 2));
      kw   = delays[$urandom_range(0, 7)];
      kr   = delays[$urandom_range(0, 7)];
      hw   = int'($urandom_range(0, 3));
      hr   = int'($urandom_range(0, 3));
      strb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (op)
        0: do_write(16'($urandom), $urandom, strb, kw, hw);
        1: do_read(16'($urandom), $urandom, kr, hr);
        default: fork
          do_write(16'($urandom), $urandom, strb, kw, hw);
          do_read(16'($urandom), $urandom, kr, hr);
        join
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
